opb_master_bridge: RTL and testbench

OPB_MASTER_BRIDGE -- requirements
Module: opb_master_bridge

---
 rtl/opb_master_bridge.sv | 185 ++++++++++++++++++
 tb/tb_opb_master_bridge.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_bridge.sv
// OPB master bridge: accepts one command at a time on a valid/ready channel and runs it
// as a single OPB master transfer. The bridge handles arbitration, retry, error and
// timeout, and returns one response per accepted command.
//
// Ports
//   OPB_Clk, OPB_Rst_n      clock, asynchronous active-low reset
//   cmd_*                   command channel (cmd_ready high only in idle)
//   rsp_valid/rdata/status  one-cycle response pulse; rdata/status hold between responses
//                           status: 00 ok, 01 errAck, 10 timeout, 11 retries exhausted
//   M_*                     OPB master outputs (zero while M_select is low, except M_request)
//   OPB_*                   OPB arbiter/slave inputs
module opb_master_bridge #(
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_TIMEOUT    = 16,
    parameter int unsigned C_MAX_RETRY  = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    // command channel
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]   cmd_addr,
    input  logic [0:C_OPB_DWIDTH-1]   cmd_wdata,
    input  logic [0:C_OPB_DWIDTH/8-1] cmd_be,
    // response channel
    output logic                      rsp_valid,
    output logic [0:C_OPB_DWIDTH-1]   rsp_rdata,
    output logic [1:0]                rsp_status,
    // OPB master outputs
    output logic                      M_request,
    output logic                      M_busLock,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic                      M_seqAddr,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    // OPB master inputs
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

    localparam int unsigned BeWidth    = C_OPB_DWIDTH / 8;
    localparam int unsigned ToutWidth  = $clog2(C_TIMEOUT + 1);
    // +2 keeps the width non-zero even when no retries are allowed
    localparam int unsigned RetryWidth = $clog2(C_MAX_RETRY + 2);

    localparam logic [ToutWidth-1:0]  ToutLimit  = ToutWidth'(C_TIMEOUT);
    localparam logic [RetryWidth-1:0] RetryLimit = RetryWidth'(C_MAX_RETRY);

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatErrAck  = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;
    localparam logic [1:0] StatRetry   = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StResp} state_e;

    state_e                    state_q, state_d;
    logic                      rnw_q, rnw_d;
    logic [0:C_OPB_AWIDTH-1]   addr_q, addr_d;
    logic [0:C_OPB_DWIDTH-1]   wdata_q, wdata_d;
    logic [0:BeWidth-1]        be_q, be_d;
    logic [RetryWidth-1:0]     retry_q, retry_d;
    logic [ToutWidth-1:0]      tout_q, tout_d;
    logic [0:C_OPB_DWIDTH-1]   rdata_q, rdata_d;
    logic [1:0]                status_q, status_d;
    logic [ToutWidth-1:0]      tout_inc;

    assign tout_inc = tout_q + ToutWidth'(1);

    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        retry_d  = retry_q;
        tout_d   = tout_q;
        rdata_d  = rdata_q;
        status_d = status_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    rnw_d   = cmd_rnw;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
                    retry_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (OPB_MGrant) begin
                    tout_d  = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // Priority: xferAck > errAck > retry > timeout
                if (OPB_xferAck) begin
                    // Writes return zero data; only reads sample the bus
                    rdata_d  = rnw_q ? OPB_DBus : '0;
                    status_d = OPB_errAck ? StatErrAck : StatOk;
                    state_d  = StResp;
                end else if (OPB_errAck) begin
                    rdata_d  = '0;
                    status_d = StatErrAck;
                    state_d  = StResp;
                end else if (OPB_retry) begin
                    if (retry_q < RetryLimit) begin
                        retry_d = retry_q + RetryWidth'(1);
                        state_d = StReq;
                    end else begin
                        rdata_d  = '0;
                        status_d = StatRetry;
                        state_d  = StResp;
                    end
                end else if (!OPB_toutSup) begin
                    tout_d = tout_inc;
                    if (tout_inc >= ToutLimit) begin
                        rdata_d  = '0;
                        status_d = StatTimeout;
                        state_d  = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= StIdle;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            retry_q  <= '0;
            tout_q   <= '0;
            rdata_q  <= '0;
            status_q <= StatOk;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            retry_q  <= retry_d;
            tout_q   <= tout_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    // Outputs decode from registered state only; select gates every bus output so the
    // bridge contributes zeros to the wired-OR bus when it is not the active master.
    // cmd_ready is also gated by reset so nothing looks acceptable while held in reset.
    always_comb begin
        cmd_ready  = (state_q == StIdle) && OPB_Rst_n;
        rsp_valid  = (state_q == StResp);
        rsp_rdata  = rdata_q;
        rsp_status = status_q;
        M_request  = (state_q == StReq);
        M_select   = (state_q == StXfer);
        M_busLock  = 1'b0;
        M_seqAddr  = 1'b0;
        M_RNW      = M_select & rnw_q;
        M_ABus     = M_select ? addr_q : '0;
        M_BE       = M_select ? be_q : '0;
        M_DBus     = (M_select && !rnw_q) ? wdata_q : '0;
    end

endmodule

// File: tb/tb_opb_master_bridge.sv
// Bench for opb_master_bridge: a driver issues commands and plays the OPB arbiter and
// slave, pushing the reference-model response into a queue; a monitor pops and compares
// every response the bridge presents and checks the bus idle rule every cycle.
module tb_opb_master_bridge;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 4;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] d;
    } exp_t;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [0:31] cmd_addr = '0;
    logic [0:31] cmd_wdata = '0;
    logic [0:3]  cmd_be = '0;
    logic        rsp_valid;
    logic [0:31] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
    logic [0:31] M_ABus;
    logic [0:3]  M_BE;
    logic [0:31] M_DBus;
    logic        OPB_MGrant = 1'b0;
    logic        OPB_xferAck = 1'b0;
    logic        OPB_errAck = 1'b0;
    logic        OPB_retry = 1'b0;
    logic        OPB_toutSup = 1'b0;
    logic [0:31] OPB_DBus = '0;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rsp_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    opb_master_bridge #(
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_TIMEOUT   (TIMEOUT),
        .C_MAX_RETRY (MAX_RETRY)
    ) dut (
        .OPB_Clk    (OPB_Clk),
        .OPB_Rst_n  (OPB_Rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rnw    (cmd_rnw),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_be     (cmd_be),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .M_request  (M_request),
        .M_busLock  (M_busLock),
        .M_select   (M_select),
        .M_RNW      (M_RNW),
        .M_seqAddr  (M_seqAddr),
        .M_ABus     (M_ABus),
        .M_BE       (M_BE),
        .M_DBus     (M_DBus),
        .OPB_MGrant (OPB_MGrant),
        .OPB_xferAck(OPB_xferAck),
        .OPB_errAck (OPB_errAck),
        .OPB_retry  (OPB_retry),
        .OPB_toutSup(OPB_toutSup),
        .OPB_DBus   (OPB_DBus)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    always @(posedge OPB_Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the response depends only on what the slave did to the command.
    // fin: 0 xferAck, 1 errAck, 2 xferAck+errAck, 3 never answers
    function automatic exp_t ref_model(input logic rnw, input logic [31:0] rdat,
                                       input int n_retry, input int fin);
        exp_t e;
        if (n_retry > MAX_RETRY) begin
            e.st = 2'b11;
            e.d  = 32'h0;
        end else begin
            case (fin)
                0:       begin e.st = 2'b00; e.d = rnw ? rdat : 32'h0; end
                1:       begin e.st = 2'b01; e.d = 32'h0; end
                2:       begin e.st = 2'b01; e.d = rnw ? rdat : 32'h0; end
                default: begin e.st = 2'b10; e.d = 32'h0; end
            endcase
        end
        return e;
    endfunction

    // Monitor: response scoreboard plus bus rules.
    always @(negedge OPB_Clk) begin
        exp_t e;
        if (OPB_Rst_n) begin
            check("busLock_zero", 32'(M_busLock), 32'h0);
            check("seqAddr_zero", 32'(M_seqAddr), 32'h0);
            if (!M_select) begin
                check("idle_abus", M_ABus, 32'h0);
                check("idle_dbus", M_DBus, 32'h0);
                check("idle_be_rnw", {27'h0, M_BE, M_RNW}, 32'h0);
            end
            if (rsp_valid) begin
                if (prev_valid) check("rsp_valid_one_cycle", 32'(prev_valid), 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_status", 32'(rsp_status), 32'(e.st));
                    check("rsp_rdata", rsp_rdata, e.d);
                    rsp_cyc <= cyc;
                end
            end
        end else if (rsp_valid) begin
            check("rsp_in_reset", 32'(rsp_valid), 32'h0);
        end
        prev_valid <= rsp_valid;
    end

    task automatic run_txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] rdat, input int n_retry,
                           input int fin, input int ts, input int gdly, input int adly,
                           input bit chk_lat);
        exp_t e;
        int   n;
        int   grants;
        int   sel;
        bit   done;
        e = ref_model(rnw, rdat, n_retry, fin);
        @(negedge OPB_Clk);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = be;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge OPB_Clk); n++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        acc_cyc = cyc;
        exp_q.push_back(e);
        @(negedge OPB_Clk);
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 32'(cmd_ready), 32'h0);
        grants = 0;
        done   = 1'b0;
        for (int att = 0; att <= MAX_RETRY && !done; att++) begin
            n = 0;
            while (!M_request && n < 50) begin @(negedge OPB_Clk); n++; end
            if (!M_request) begin
                check("request_wait", 32'(M_request), 32'h1);
                break;
            end
            grants++;
            repeat (gdly) @(negedge OPB_Clk);
            OPB_MGrant = 1'b1;
            @(negedge OPB_Clk);
            OPB_MGrant = 1'b0;
            check("select_after_grant", 32'(M_select), 32'h1);
            check("request_dropped", 32'(M_request), 32'h0);
            check("xfer_abus", M_ABus, addr);
            check("xfer_be_rnw", {27'h0, M_BE, M_RNW}, {27'h0, be, rnw});
            check("xfer_dbus", M_DBus, rnw ? 32'h0 : wdata);
            if (att < n_retry) begin
                repeat (adly) @(negedge OPB_Clk);
                OPB_retry = 1'b1;
                @(negedge OPB_Clk);
                OPB_retry = 1'b0;
                check("select_drop_retry", 32'(M_select), 32'h0);
                if (att == MAX_RETRY) done = 1'b1;
            end else begin
                if (fin == 3) begin
                    sel = 0;
                    while (M_select && sel < 200) begin
                        OPB_toutSup = (sel < ts);
                        @(negedge OPB_Clk);
                        sel++;
                    end
                    OPB_toutSup = 1'b0;
                    check("select_cycles", 32'(sel), 32'(TIMEOUT + ts));
                end else begin
                    repeat (adly) @(negedge OPB_Clk);
                    OPB_xferAck = (fin != 1);
                    OPB_errAck  = (fin != 0);
                    OPB_DBus    = rdat;
                    @(negedge OPB_Clk);
                    OPB_xferAck = 1'b0;
                    OPB_errAck  = 1'b0;
                    OPB_DBus    = '0;
                    check("select_drop_ack", 32'(M_select), 32'h0);
                end
                done = 1'b1;
            end
        end
        check("grant_count", 32'(grants),
              32'((n_retry > MAX_RETRY) ? MAX_RETRY + 1 : n_retry + 1));
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(negedge OPB_Clk); n++; end
        check("rsp_seen", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        if (chk_lat) check("latency", 32'(rsp_cyc - acc_cyc), 32'h3);
        @(negedge OPB_Clk);
        check("rsp_hold_status", 32'(rsp_status), 32'(e.st));
        check("rsp_hold_data", rsp_rdata, e.d);
    endtask

    task automatic reset_mid_xfer();
        int n;
        @(negedge OPB_Clk);
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 32'h0000_0020;
        cmd_wdata = 32'h1234_5678;
        cmd_be    = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge OPB_Clk); n++; end
        @(negedge OPB_Clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!M_request && n < 50) begin @(negedge OPB_Clk); n++; end
        OPB_MGrant = 1'b1;
        @(negedge OPB_Clk);
        OPB_MGrant = 1'b0;
        check("rst_pre_select", 32'(M_select), 32'h1);
        #2 OPB_Rst_n = 1'b0;
        #1;
        check("rst_select", 32'(M_select), 32'h0);
        check("rst_request", 32'(M_request), 32'h0);
        check("rst_abus", M_ABus, 32'h0);
        check("rst_dbus", M_DBus, 32'h0);
        check("rst_be_rnw", {27'h0, M_BE, M_RNW}, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_rsp", {29'h0, rsp_valid, rsp_status}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(negedge OPB_Clk);
        #2 OPB_Rst_n = 1'b1;
        repeat (5) @(negedge OPB_Clk);
    endtask

    initial begin
        logic        r;
        logic [31:0] a, w, d;
        logic [3:0]  b;
        #1;
        check("reset_outputs", {26'h0, cmd_ready, rsp_valid, M_request, M_select, rsp_status},
              32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        repeat (3) @(negedge OPB_Clk);
        #2 OPB_Rst_n = 1'b1;
        @(negedge OPB_Clk);

        // directed cases
        run_txn(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0, 0, 0, 1'b1);
        run_txn(1'b1, 32'h0000_0004, 32'h0, 4'hF, 32'hBABE_0100, 0, 0, 0, 0, 0, 1'b1);
        run_txn(1'b1, 32'h0000_0008, 32'h0, 4'hF, 32'h0, 0, 3, 0, 0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0008, 32'h0, 4'hF, 32'h0, 0, 3, 5, 0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 32'hCAFE_F00D, 4'h3, 32'h0, 9, 0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0044, 32'h0, 4'hF, 32'h5555_AAAA, 1, 0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_0048, 32'h0, 4'hF, 32'h0F0F_1234, 0, 2, 0, 0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_004C, 32'h7777_0000, 4'h8, 32'h0, 0, 1, 0, 1, 2, 1'b0);
        reset_mid_xfer();
        run_txn(1'b1, 32'h0000_0100, 32'h0, 4'hF, 32'hA5A5_5A5A, 0, 0, 0, 0, 0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            a = $urandom;
            w = $urandom;
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            run_txn(r, a, w, b, d, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
